// File: rtl/pipe_adder_pkg.sv
// Shared definitions for the pipelined-adder scheduler: pipeline geometry,
// scheduler states and the requester-ID width helper.
package pipe_adder_pkg;

    localparam int PIPE_DEPTH = 4;
    localparam int SLICE_W    = 8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    function automatic int id_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pipe_adder_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last winner and
// grants the first active request.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDW-1:0]   winner,
    output logic             any
);
    logic [IDW-1:0] cand;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % N_REQ);
            if (!any && req[cand]) begin
                grant[cand] = 1'b1;
                winner      = cand;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with a synchronous clear. A write is accepted while
// full when a read happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_wr, do_rd;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_wr) begin
                wr_ptr_d = (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_d = (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (do_wr && !do_rd) begin
                count_d = count_q + 1'b1;
            end else if (!do_wr && do_rd) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/pipe_adder_ctrl.sv
// Shares one 4-stage pipelined adder among N_REQ requesters with round-robin,
// credit-gated issue, in-order tagged result buffering and a flush path.
module pipe_adder_ctrl
    import pipe_adder_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 32,
    parameter int RSP_DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    output logic [N_REQ-1:0]          req_ready,
    input  logic [N_REQ*WIDTH-1:0]    req_a,
    input  logic [N_REQ*WIDTH-1:0]    req_b,
    input  logic [N_REQ-1:0]          req_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [id_width(N_REQ)-1:0] rsp_id,
    output logic [WIDTH-1:0]          rsp_sum,
    output logic                      rsp_cout,
    input  logic                      flush,
    output logic                      busy,
    output logic                      adder_valid_in,
    output logic                      adder_cin,
    output logic [WIDTH-1:0]          adder_a,
    output logic [WIDTH-1:0]          adder_b,
    output logic                      adder_out_allow,
    output logic [3:0]                adder_pause,
    output logic [3:0]                adder_refresh,
    input  logic                      adder_valid_out,
    input  logic                      adder_cout,
    input  logic [WIDTH-1:0]          adder_sum
);
    localparam int IDW = id_width(N_REQ);
    localparam int CW  = $clog2(RSP_DEPTH + 1);
    localparam int RW  = IDW + 1 + WIDTH;

    state_e         state_q, state_d;
    logic [3:0]     refresh_q, refresh_d;
    logic           armed_q, armed_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [CW-1:0]  inflight_q, inflight_d;
    logic [CW-1:0]  rsp_count_q, rsp_count_d;

    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   winner;
    logic             grant_any;
    logic [CW:0]      outstanding;
    logic             flushing, credit_ok, can_issue, issue, retire, rsp_pop;
    logic [IDW-1:0]   tag_head;
    logic             tag_empty, tag_full;
    logic [RW-1:0]    res_head;
    logic             res_empty, res_full;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .grant  (grant),
        .winner (winner),
        .any    (grant_any)
    );

    // Reserving a result slot per issued op is what lets the adder run without stalls.
    assign flushing    = (state_q == FLUSH);
    assign outstanding = {1'b0, inflight_q} + {1'b0, rsp_count_q};
    assign credit_ok   = outstanding < (CW + 1)'(RSP_DEPTH);
    assign can_issue   = armed_q && !flushing && !flush && credit_ok;
    assign issue       = can_issue && grant_any;
    assign retire      = adder_valid_out && !flushing && !flush;
    assign rsp_valid   = !res_empty && !flushing;
    assign rsp_pop     = rsp_valid && rsp_ready;

    assign req_ready       = can_issue ? grant : '0;
    assign adder_valid_in  = issue;
    assign adder_a         = req_a[int'(winner)*WIDTH +: WIDTH];
    assign adder_b         = req_b[int'(winner)*WIDTH +: WIDTH];
    assign adder_cin       = req_cin[winner];
    assign adder_out_allow = 1'b1;
    assign adder_pause     = '0;
    assign adder_refresh   = refresh_q;

    assign rsp_id   = res_head[RW-1 -: IDW];
    assign rsp_cout = res_head[WIDTH];
    assign rsp_sum  = res_head[WIDTH-1:0];
    assign busy     = (inflight_q != '0) || (rsp_count_q != '0) || flushing;

    sync_fifo #(.WIDTH(IDW), .DEPTH(PIPE_DEPTH)) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (flushing),
        .wr_en   (issue),
        .wr_data (winner),
        .rd_en   (retire),
        .rd_data (tag_head),
        .empty   (tag_empty),
        .full    (tag_full)
    );

    sync_fifo #(.WIDTH(RW), .DEPTH(RSP_DEPTH)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (flushing),
        .wr_en   (retire),
        .wr_data ({tag_head, adder_cout, adder_sum}),
        .rd_en   (rsp_pop),
        .rd_data (res_head),
        .empty   (res_empty),
        .full    (res_full)
    );

    // Grants stay off until the first edge after reset release.
    always_comb begin
        state_d     = flush ? FLUSH : RUN;
        refresh_d   = flush ? 4'hF : 4'h0;
        armed_d     = 1'b1;
        ptr_d       = issue ? winner : ptr_q;
        inflight_d  = inflight_q;
        rsp_count_d = rsp_count_q;
        if (flushing) begin
            inflight_d  = '0;
            rsp_count_d = '0;
        end else begin
            if (issue && !retire) begin
                inflight_d = inflight_q + 1'b1;
            end else if (!issue && retire) begin
                inflight_d = inflight_q - 1'b1;
            end
            if (retire && !rsp_pop) begin
                rsp_count_d = rsp_count_q + 1'b1;
            end else if (!retire && rsp_pop) begin
                rsp_count_d = rsp_count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            refresh_q   <= 4'h0;
            armed_q     <= 1'b0;
            ptr_q       <= IDW'(N_REQ - 1);
            inflight_q  <= '0;
            rsp_count_q <= '0;
        end else begin
            state_q     <= state_d;
            refresh_q   <= refresh_d;
            armed_q     <= armed_d;
            ptr_q       <= ptr_d;
            inflight_q  <= inflight_d;
            rsp_count_q <= rsp_count_d;
        end
    end

    a_tag_underflow: assert property (@(posedge clk) disable iff (!rst) retire |-> !tag_empty);
    a_tag_overflow:  assert property (@(posedge clk) disable iff (!rst) issue |-> (!tag_full || retire));
    a_res_overflow:  assert property (@(posedge clk) disable iff (!rst) retire |-> !res_full);

endmodule

// File: doc/pipe_adder_ctrl.md
# pipe_adder_ctrl

Scheduler that shares one 4-stage stallable pipelined adder (WIDTH bits, 8-bit slices, carry-in/carry-out) between N_REQ requesters. Round-robin arbitration picks one request per cycle. Issue is credit-gated so the adder never has to stall. Each operation is tagged with its requester ID, results are buffered in order, and they are returned on one shared response port. A flush command cancels all in-flight work via the adder's per-stage refresh.

## Interface
- N_REQ, 4: number of requesters (2..8).
- WIDTH, 32: operand/sum width; must equal adder WIDTH.
- RSP_DEPTH, 8: result buffer entries; must be ≥ PIPE_DEPTH (4).
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester request.
- req_ready  out  N_REQ  one-hot grant; transfer when valid&ready.
- req_a, req_b  in  N_REQ*WIDTH  operands, requester i at [i*WIDTH +: WIDTH].
- req_cin  in  N_REQ  carry-in per requester.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts.
- rsp_id  out  clog2(N_REQ)  originating requester.
- rsp_sum  out  WIDTH  sum; rsp_cout out 1 carry-out.
- flush  in  1  cancel all in-flight and buffered operations.
- busy  out  1  any operation in flight or buffered.
- adder_valid_in, adder_cin  out  1; adder_a, adder_b  out  WIDTH: issue to adder.
- adder_out_allow  out  1  tied 1.
- adder_pause  out  4  tied 0.
- adder_refresh  out  4  stage clears.
- adder_valid_out, adder_cout  in  1; adder_sum  in  WIDTH: adder result.

## Operation
- States: RUN, FLUSH. Reset → RUN.
- Reset values: req_ready=0, rsp_valid=0, busy=0, adder_valid_in=0, adder_refresh=0, rr pointer=N_REQ-1 (requester 0 wins first), all counters 0.
- Credits: inflight (issued, not yet returned) + rsp_count (buffered) ≤ RSP_DEPTH. Issue is allowed only when the sum < RSP_DEPTH.
  - Because a result slot is always reserved, adder_out_allow stays 1, no stage ever stalls, and every adder_valid_in=1 is accepted the same cycle.
- Arbitration (RUN, credit available, flush=0):
  - Search starts at pointer+1 mod N_REQ; the first asserted req_valid is granted.
  - req_ready is high only for the winner. The winner's operands/cin drive adder_a/b/cin with adder_valid_in=1.
  - The winner's ID is pushed to the tag FIFO (PIPE_DEPTH deep); pointer ← winner.
  - With no request: adder_valid_in=0 and the pointer holds.
- Retire: on adder_valid_out=1, pop the tag FIFO and push {tag, adder_cout, adder_sum} into the result FIFO. The pipeline is in-order, so tag order equals result order.
- Response: rsp_* show the result FIFO head, rsp_valid = not empty; pop on rsp_valid&rsp_ready.
- Counters: issue, retire and pop in the same cycle update inflight/rsp_count by their net sum.
- flush=1 (any state):
  - Same cycle: req_ready=0, no issue, adder_valid_out ignored. A response handshake in this cycle still completes.
  - Next cycle: FLUSH.
- FLUSH (exactly one cycle):
  - adder_refresh=4'b1111, req_ready=0, rsp_valid=0, adder_valid_out ignored.
  - At its end, tag FIFO, result FIFO, inflight and rsp_count clear; pointer holds; → RUN.
  - flush still high at that edge gives another FLUSH cycle.
- busy = (inflight≠0) | (rsp_count≠0) | (state==FLUSH).
- Error condition: adder_valid_out with an empty tag FIFO is flagged by a simulation assertion only.

## Timing
- Grant is combinational from req_valid and registered state; no request→grant register.
- Issue-to-rsp_valid latency is 4 adder cycles + 1 buffer write = 5 cycles when the result FIFO is empty.
- Sustained throughput is 1 op/cycle while rsp_ready=1.
- With rsp_ready=0, at most RSP_DEPTH operations are issued, then req_ready stays 0 until a pop.
- An asynchronous rst assertion mid-operation clears everything immediately. Behaviour after release matches the reset values.

## Structure
- Shared package pipe_adder_pkg: PIPE_DEPTH=4, SLICE_W=8, state encoding (RUN, FLUSH), ID-width function.
- Sub-module rr_arbiter: N_REQ requests plus pointer in, one-hot grant and encoded winner out.
- Both FIFOs use the existing generic sync FIFO: tag FIFO of depth PIPE_DEPTH, result FIFO of depth RSP_DEPTH.

## Test plan
- Single op: req0 issues a=0xFFFF_FFFF, b=1, cin=0 → 5 cycles later rsp_id=0, rsp_sum=0, rsp_cout=1; busy then drops.
- Round robin: all 4 requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0,…; responses arrive in the same order at 1 per cycle.
- Backpressure: rsp_ready=0 with req1 continuously valid → exactly 8 issues, req_ready=0 afterwards; raising rsp_ready drains the 8 results in issue order and issue resumes.
- Credit edge: RSP_DEPTH-1 outstanding, then a pop and an issue in the same cycle → the total stays at RSP_DEPTH-1 and the issue is accepted.
- Flush: 3 ops in flight plus 2 buffered, pulse flush → the next cycle shows adder_refresh=1111; no stale response ever appears; busy=0 one cycle after FLUSH; a new op completes correctly.
- Reset: assert rst while 4 ops are in flight → all outputs return to reset values at once; after release requester 0 is granted first.
